// File: rtl/ifu_dbpu.sv
// ifu_dbpu: decode-stage branch predictor for the IFU.
// Provides a per-instruction taken prediction and the two next-PC adder operands.
// A bimodal BHT (valid bit + 2-bit counter) predicts conditional branches, and
// falls back to backward-taken/forward-not-taken on entries never trained.
// Optional return-address stack: define IFU_DBPU_RAS_EN to enable it. Without it,
// returns through x1 use the register-file value and bpu_flush is ignored.

module ifu_dbpu #(
    parameter int PC_SIZE   = 32,
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_SIZE-1:0] pc,
    input  logic               dec_i_valid,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [PC_SIZE-1:0] dec_bjp_imm,
    input  logic [4:0]         dec_jalr_rs1idx,
    input  logic [4:0]         dec_rdidx,
    input  logic               dec_ack,
    input  logic [PC_SIZE-1:0] rf2bpu_x1,
    input  logic [PC_SIZE-1:0] rf2bpu_rs1,
    input  logic               upd_valid,
    input  logic [PC_SIZE-1:0] upd_pc,
    input  logic               upd_taken,
    input  logic               bpu_flush,
    output logic               prdt_taken,
    output logic [PC_SIZE-1:0] prdt_pc_add_op1,
    output logic [PC_SIZE-1:0] prdt_pc_add_op2
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    logic [BHT_DEPTH-1:0] bht_vld;
    logic [1:0]           bht_cnt [BHT_DEPTH];
    logic [IDX_W-1:0]     lkp_idx;
    logic [IDX_W-1:0]     upd_idx;
    logic                 bht_pred;

    // Whole-word branch addresses: the low two PC bits never select an entry.
    assign lkp_idx = pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];

    // Only the index bits of upd_pc matter; the rest is deliberately ignored.
    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc;

    // BHT training; lookups in the same cycle see the pre-update entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_vld <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_cnt[i] <= CNT_SNT;
            end
        end else if (upd_valid) begin
            bht_vld[upd_idx] <= 1'b1;
            if (!bht_vld[upd_idx]) begin
                bht_cnt[upd_idx] <= upd_taken ? CNT_WT : CNT_WNT;
            end else if (upd_taken && (bht_cnt[upd_idx] != CNT_ST)) begin
                bht_cnt[upd_idx] <= bht_cnt[upd_idx] + 2'b01;
            end else if (!upd_taken && (bht_cnt[upd_idx] != CNT_SNT)) begin
                bht_cnt[upd_idx] <= bht_cnt[upd_idx] - 2'b01;
            end
        end
    end

    // Untrained entries use the offset sign: backward branches are loops.
    assign bht_pred = bht_vld[lkp_idx] ? bht_cnt[lkp_idx][1] : dec_bjp_imm[PC_SIZE-1];

    logic               ras_hit;
    logic [PC_SIZE-1:0] ras_top;

`ifdef IFU_DBPU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_SIZE-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr;
    logic [PTR_W-1:0]   ras_top_ptr;
    logic [CNT_W-1:0]   ras_cnt;
    logic               dec_fire;
    logic               ras_push;
    logic               ras_pop;
    logic               ras_pop_req;

    // ras_ptr is the next write slot; when full it is also the oldest entry,
    // so a push while full naturally overwrites the oldest return address.
    assign ras_top_ptr = ras_ptr - PTR_W'(1);
    assign ras_top     = ras_mem[ras_top_ptr];
    assign dec_fire    = dec_i_valid & dec_ack;
    assign ras_pop_req = dec_jalr & (dec_jalr_rs1idx == 5'd1) & (dec_rdidx == 5'd0);
    assign ras_hit     = ras_pop_req & (ras_cnt != '0);
    assign ras_push    = dec_fire & (dec_jal | dec_jalr) & (dec_rdidx == 5'd1);
    assign ras_pop     = dec_fire & ras_hit;

    // RAS pointer and occupancy; flush empties the stack without moving the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (bpu_flush) begin
            ras_cnt <= '0;
        end else if (ras_push && ras_pop) begin
            ras_ptr <= ras_ptr;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_cnt != RAS_FULL) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_ptr <= ras_top_ptr;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    // RAS storage; a combined push/pop rewrites the current top in place.
    always_ff @(posedge clk) begin
        if (rst_n && !bpu_flush && ras_push) begin
            ras_mem[(ras_push && ras_pop) ? ras_top_ptr : ras_ptr] <= pc + PC_SIZE'(4);
        end
    end
`else
    assign ras_hit = 1'b0;
    assign ras_top = '0;

    // Stack-related decode inputs have no consumer in this build.
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{bpu_flush, dec_i_valid, dec_ack, dec_rdidx};
`endif

    // Taken prediction: jumps always, conditional branches from the BHT.
    assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bht_pred);

    // Next-PC adder operand selection.
    always_comb begin
        prdt_pc_add_op1 = rf2bpu_rs1;
        prdt_pc_add_op2 = dec_bjp_imm;
        if (dec_bxx || dec_jal) begin
            prdt_pc_add_op1 = pc;
        end else if (dec_jalr) begin
            if (dec_jalr_rs1idx == 5'd0) begin
                prdt_pc_add_op1 = '0;
            end else if (ras_hit) begin
                prdt_pc_add_op1 = ras_top;
                prdt_pc_add_op2 = '0;
            end else if (dec_jalr_rs1idx == 5'd1) begin
                prdt_pc_add_op1 = rf2bpu_x1;
            end
        end
    end

endmodule
